// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC core widths and types
package pic_pkg;
  localparam int PC_W        = 8;
  localparam int STACK_DEPTH = 8;
  typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - decoder <-> return-address stack signal bundle
// Sticky overflow/underflow signals exist only when STACK_FLAGS_EN is defined.
interface call_stack_if
  import pic_pkg::*;
#(
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = PC_W
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] top;
  logic [LW-1:0]     level;
  logic              empty;
  logic              full;
`ifdef STACK_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (output push, pop, ret_addr,
                  input  top, level, empty, full, overflow, underflow);
  modport slave  (input  push, pop, ret_addr,
                  output top, level, empty, full, overflow, underflow);
`else
  modport master (output push, pop, ret_addr,
                  input  top, level, empty, full);
  modport slave  (input  push, pop, ret_addr,
                  output top, level, empty, full);
`endif
endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x ADDR_W register array, sync write, async read
module stack_ram #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [ADDR_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]        rd_data
);
  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - circular return-address stack (PIC16 style, overflow wraps)
// Optional sticky overflow/underflow flags under STACK_FLAGS_EN.
module call_stack
  import pic_pkg::*;
#(
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = PC_W
) (
  input logic         clk,
  input logic         reset,
  call_stack_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  logic [IW-1:0]     sp;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;
  logic [LW-1:0]     lvl;
  logic [ADDR_W-1:0] rd_data;
  logic              is_empty;
  logic              is_full;
  logic              replace;

  // DEPTH is a power of two, so pointer arithmetic wraps for free
  assign top_idx  = sp - 1'b1;
  assign is_empty = (lvl == '0);
  assign is_full  = (lvl == LW'(DEPTH));
  assign replace  = bus.push && bus.pop && !is_empty;
  assign wr_idx   = replace ? top_idx : sp;

  stack_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.push),
    .wr_idx  (wr_idx),
    .wr_data (bus.ret_addr),
    .rd_idx  (top_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      lvl <= '0;
    end else if (bus.push && !replace) begin
      sp <= sp + 1'b1;
      if (!is_full) lvl <= lvl + 1'b1;
    end else if (bus.pop && !bus.push && !is_empty) begin
      sp  <= sp - 1'b1;
      lvl <= lvl - 1'b1;
    end
  end

`ifdef STACK_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.push && !bus.pop && is_full)  bus.overflow  <= 1'b1;
      if (bus.pop && !bus.push && is_empty) bus.underflow <= 1'b1;
    end
  end
`endif

  assign bus.top   = is_empty ? '0 : rd_data;
  assign bus.level = lvl;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
endmodule
